// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD arbiter slice.
package gcd_pkg;

    localparam int GCD_WIDTH   = 32;
    localparam int GCD_TIMEOUT = 65535;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESP
    } gcd_state_t;

endpackage

// File: rtl/gcd_arbiter_if.sv
// Requester-side and GCD-unit-side signals of the arbiter, bundled together.
interface gcd_arbiter_if #(parameter int WIDTH = gcd_pkg::GCD_WIDTH);

    logic [1:0]       req;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [1:0]       ack;
    logic [1:0]       grant;
    logic [WIDTH-1:0] result;
    logic             error;
    logic             timeout;
    logic             busy;
    logic             gcd_start;
    logic [WIDTH-1:0] gcd_a;
    logic [WIDTH-1:0] gcd_b;
    logic             gcd_done;
    logic [WIDTH-1:0] gcd_result;
    logic             gcd_error;

    // slave is the arbiter itself; master is everything around it
    modport slave (
        input  req, a0, b0, a1, b1, gcd_done, gcd_result, gcd_error,
        output ack, grant, result, error, timeout, busy, gcd_start, gcd_a, gcd_b
    );

    modport master (
        output req, a0, b0, a1, b1, gcd_done, gcd_result, gcd_error,
        input  ack, grant, result, error, timeout, busy, gcd_start, gcd_a, gcd_b
    );

endinterface

// File: rtl/gcd_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, on a tie the one not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one external GCD unit between two requesters; every output is a register
// loaded from the next-value logic of the FSM.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input logic          clk,
    input logic          rst,
    gcd_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    gcd_state_t       state_q, state_n;
    logic [1:0]       grant_q, grant_n;
    logic [1:0]       ack_q, ack_n;
    logic [1:0]       pick;
    logic             start_q, start_n;
    logic             busy_q, busy_n;
    logic [WIDTH-1:0] opa_q, opa_n;
    logic [WIDTH-1:0] opb_q, opb_n;
    logic [WIDTH-1:0] result_q, result_n;
    logic             error_q, error_n;
    logic             timeout_q, timeout_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             last_q, last_n;
    logic             done_q;
    logic             done_edge;

    rr_arb2 u_arb (
        .req  (bus.req),
        .last (last_q),
        .pick (pick)
    );

    // A done level left over from the previous operation must not complete this one
    assign done_edge = bus.gcd_done & ~done_q;

    always_comb begin
        state_n   = state_q;
        grant_n   = grant_q;
        ack_n     = 2'b00;
        start_n   = 1'b0;
        opa_n     = opa_q;
        opb_n     = opb_q;
        result_n  = result_q;
        error_n   = error_q;
        timeout_n = timeout_q;
        cnt_n     = cnt_q;
        last_n    = last_q;
        case (state_q)
            ST_IDLE: begin
                grant_n = 2'b00;
                if (pick != 2'b00) begin
                    state_n = ST_START;
                    grant_n = pick;
                    start_n = 1'b1;
                    last_n  = pick[1];
                    opa_n   = pick[1] ? bus.a1 : bus.a0;
                    opb_n   = pick[1] ? bus.b1 : bus.b0;
                end
            end
            ST_START: begin
                state_n = ST_WAIT;
                cnt_n   = '0;
            end
            ST_WAIT: begin
                if (done_edge) begin
                    state_n   = ST_RESP;
                    ack_n     = grant_q;
                    result_n  = bus.gcd_result;
                    error_n   = bus.gcd_error;
                    timeout_n = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_n   = ST_RESP;
                    ack_n     = grant_q;
                    result_n  = '0;
                    error_n   = 1'b1;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
                grant_n = 2'b00;
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = 2'b00;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            ack_q     <= 2'b00;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            grant_q   <= grant_n;
            ack_q     <= ack_n;
            start_q   <= start_n;
            busy_q    <= busy_n;
            opa_q     <= opa_n;
            opb_q     <= opb_n;
            result_q  <= result_n;
            error_q   <= error_n;
            timeout_q <= timeout_n;
            cnt_q     <= cnt_n;
            last_q    <= last_n;
            done_q    <= bus.gcd_done;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.gcd_start = start_q;
    assign bus.gcd_a     = opa_q;
    assign bus.gcd_b     = opb_q;
    assign bus.result    = result_q;
    assign bus.error     = error_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter with a behavioural GCD unit (latency, sticky done, stall).
module tb_gcd_arbiter;

    localparam int W = 32;

    typedef struct packed {
        logic [1:0]   who;
        logic [W-1:0] res;
        logic         err;
        logic         to;
    } exp_t;

    typedef struct {
        exp_t v;
        int   cyc;
        int   done_cyc;
        int   start_cyc;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gcd_arbiter_if #(.WIDTH(W)) bus ();

    gcd_arbiter #(.WIDTH(W), .TIMEOUT(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    obs_t obs_q[$];
    int   grant_cyc_q[$];
    obs_t o;
    exp_t e;

    // GCD unit model controls
    int   model_lat = 2;
    bit   sticky_done = 1'b0;
    bit   stall_done = 1'b0;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic exp_t mk(input int who, input logic [W-1:0] res, input logic err, input logic to);
        exp_t x;
        x.who = 2'(who);
        x.res = res;
        x.err = err;
        x.to  = to;
        return x;
    endfunction

    function automatic string fmt(input exp_t x);
        return $sformatf("who=%0d res=%0d err=%b to=%b", x.who, x.res, x.err, x.to);
    endfunction

    function automatic obs_t make_obs(input logic [1:0] ack, input logic [W-1:0] r, input logic er,
                                      input logic t, input int c, input int dc, input int sc);
        obs_t x;
        x.v.who     = (ack == 2'b01) ? 2'd0 : (ack == 2'b10) ? 2'd1 : 2'd3;
        x.v.res     = r;
        x.v.err     = er;
        x.v.to      = t;
        x.cyc       = c;
        x.done_cyc  = dc;
        x.start_cyc = sc;
        return x;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural GCD unit: done stays high until the next start (or longer when sticky)
    int           cnt_m = 0;
    int           hold = 0;
    bit           pend = 1'b0;
    logic [W-1:0] pend_res = '0;
    logic         pend_err = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            bus.gcd_done   <= 1'b0;
            bus.gcd_result <= '0;
            bus.gcd_error  <= 1'b0;
            pend           <= 1'b0;
            cnt_m          <= 0;
            hold           <= 0;
        end else if (bus.gcd_start) begin
            pend     <= 1'b1;
            cnt_m    <= model_lat;
            hold     <= sticky_done ? 3 : 0;
            pend_err <= (bus.gcd_a == 0) || (bus.gcd_b == 0);
            pend_res <= ((bus.gcd_a == 0) || (bus.gcd_b == 0)) ? '0 : ref_gcd(bus.gcd_a, bus.gcd_b);
            if (!sticky_done) bus.gcd_done <= 1'b0;
        end else if (hold != 0) begin
            hold <= hold - 1;
            if (hold == 1) bus.gcd_done <= 1'b0;
        end else if (pend && !stall_done) begin
            if (cnt_m == 0) begin
                bus.gcd_done   <= 1'b1;
                bus.gcd_result <= pend_res;
                bus.gcd_error  <= pend_err;
                pend           <= 1'b0;
            end else begin
                cnt_m <= cnt_m - 1;
            end
        end
    end

    // Output monitor: records every ack cycle plus the timing landmarks around it
    logic       done_prev = 1'b0;
    logic [1:0] grant_prev = 2'b00;
    int         last_done_cyc = 0;
    int         last_start_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.gcd_done && !done_prev) last_done_cyc <= cyc;
            if (bus.gcd_start) last_start_cyc <= cyc;
            if (bus.grant != 2'b00 && grant_prev == 2'b00) grant_cyc_q.push_back(cyc);
            if (bus.ack != 2'b00)
                obs_q.push_back(make_obs(bus.ack, bus.result, bus.error, bus.timeout,
                                         cyc, last_done_cyc, last_start_cyc));
        end
        done_prev  <= bus.gcd_done;
        grant_prev <= bus.grant;
    end

    task automatic service(input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            if (bus.ack[0]) bus.req[0] = 1'b0;
            if (bus.ack[1]) bus.req[1] = 1'b0;
            k++;
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        grant_cyc_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.ack, bus.grant, bus.busy, bus.gcd_start} !== 6'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_ctrl: got ack=%b grant=%b busy=%b start=%b, need all 0",
                     bus.ack, bus.grant, bus.busy, bus.gcd_start);
        end
        n_cmp++;
        if (bus.gcd_a !== '0 || bus.gcd_b !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_ops: got gcd_a=%0d gcd_b=%0d, need 0 0", bus.gcd_a, bus.gcd_b);
        end
        n_cmp++;
        if (bus.result !== '0 || bus.error !== 1'b0 || bus.timeout !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_resp: got res=%0d err=%b to=%b, need 0 0 0",
                     bus.result, bus.error, bus.timeout);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.grant !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL idle_after_reset: got busy=%b grant=%b, need 0 00", bus.busy, bus.grant);
        end
    endtask

    task automatic test_basic();
        clear_queues();
        model_lat = 2;
        bus.a0 = 12;
        bus.b0 = 18;
        exp_q.push_back(mk(0, 6, 1'b0, 1'b0));
        bus.req = 2'b01;
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.grant !== 2'b01 || bus.gcd_start !== 1'b1 || bus.busy !== 1'b1 ||
            bus.gcd_a !== 12 || bus.gcd_b !== 18) begin
            n_bad++;
            $display("[TB] FAIL basic_grant: got grant=%b start=%b busy=%b a=%0d b=%0d, need 01 1 1 12 18",
                     bus.grant, bus.gcd_start, bus.busy, bus.gcd_a, bus.gcd_b);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.gcd_start !== 1'b0 || bus.grant !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL basic_start_pulse: got start=%b grant=%b, need 0 01", bus.gcd_start, bus.grant);
        end
        service(1, 50);
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL basic_count: got %0d acks, need 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o.v !== e) begin
                n_bad++;
                $display("[TB] FAIL basic_resp: got %s, need %s", fmt(o.v), fmt(e));
            end
            n_cmp++;
            if (o.cyc != o.done_cyc + 1) begin
                n_bad++;
                $display("[TB] FAIL basic_latency: got ack cycle %0d, need %0d", o.cyc, o.done_cyc + 1);
            end
        end
    endtask

    task automatic test_zero_operand();
        clear_queues();
        bus.a1 = 0;
        bus.b1 = 3;
        exp_q.push_back(mk(1, 0, 1'b1, 1'b0));
        bus.req = 2'b10;
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.grant !== 2'b10 || bus.gcd_a !== 0 || bus.gcd_b !== 3) begin
            n_bad++;
            $display("[TB] FAIL zero_pass: got grant=%b a=%0d b=%0d, need 10 0 3", bus.grant, bus.gcd_a, bus.gcd_b);
        end
        service(1, 50);
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL zero_count: got %0d acks, need 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o.v !== e) begin
                n_bad++;
                $display("[TB] FAIL zero_resp: got %s, need %s", fmt(o.v), fmt(e));
            end
        end
    endtask

    task automatic test_large();
        clear_queues();
        bus.a0 = 2147483643;
        bus.b0 = 1431655762;
        exp_q.push_back(mk(0, 715827881, 1'b0, 1'b0));
        bus.req = 2'b01;
        service(1, 50);
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL large_count: got %0d acks, need 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o.v !== e) begin
                n_bad++;
                $display("[TB] FAIL large_resp: got %s, need %s", fmt(o.v), fmt(e));
            end
        end
    endtask

    task automatic test_back_to_back();
        int first_ack;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        clear_queues();
        bus.a0 = 21;
        bus.b0 = 14;
        bus.a1 = 45;
        bus.b1 = 75;
        exp_q.push_back(mk(0, 7, 1'b0, 1'b0));
        exp_q.push_back(mk(1, 15, 1'b0, 1'b0));
        bus.req = 2'b11;
        service(2, 100);
        first_ack = -100;
        n_cmp++;
        if (obs_q.size() != 2) begin
            n_bad++;
            $display("[TB] FAIL b2b_count: got %0d acks, need 2", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                if (i == 0) first_ack = o.cyc;
                n_cmp++;
                if (o.v !== e) begin
                    n_bad++;
                    $display("[TB] FAIL b2b_resp%0d: got %s, need %s", i, fmt(o.v), fmt(e));
                end
            end
        end
        n_cmp++;
        if (grant_cyc_q.size() != 2 || grant_cyc_q[1] != first_ack + 2) begin
            n_bad++;
            $display("[TB] FAIL b2b_regrant: got %0d grants, second at %0d, need 2 grants, second at %0d",
                     grant_cyc_q.size(), (grant_cyc_q.size() > 1) ? grant_cyc_q[1] : -1, first_ack + 2);
        end
    endtask

    task automatic test_round_robin();
        clear_queues();
        bus.a0 = 9;
        bus.b0 = 3;
        exp_q.push_back(mk(0, 3, 1'b0, 1'b0));
        bus.req = 2'b01;
        service(1, 50);
        bus.a0 = 8;
        bus.b0 = 12;
        bus.a1 = 10;
        bus.b1 = 25;
        exp_q.push_back(mk(1, 5, 1'b0, 1'b0));
        exp_q.push_back(mk(0, 4, 1'b0, 1'b0));
        bus.req = 2'b11;
        service(3, 100);
        n_cmp++;
        if (obs_q.size() != 3) begin
            n_bad++;
            $display("[TB] FAIL rr_count: got %0d acks, need 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                n_cmp++;
                if (o.v !== e) begin
                    n_bad++;
                    $display("[TB] FAIL rr_resp%0d: got %s, need %s", i, fmt(o.v), fmt(e));
                end
            end
        end
    endtask

    task automatic test_isolation();
        clear_queues();
        model_lat = 6;
        bus.a0 = 48;
        bus.b0 = 36;
        exp_q.push_back(mk(0, 12, 1'b0, 1'b0));
        bus.req = 2'b01;
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            bus.a0 = $urandom;
            bus.b0 = $urandom;
            bus.a1 = $urandom;
            bus.b1 = $urandom;
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (bus.gcd_a !== 48 || bus.gcd_b !== 36) begin
            n_bad++;
            $display("[TB] FAIL iso_stable: got a=%0d b=%0d, need 48 36", bus.gcd_a, bus.gcd_b);
        end
        service(1, 50);
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL iso_count: got %0d acks, need 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o.v !== e) begin
                n_bad++;
                $display("[TB] FAIL iso_resp: got %s, need %s", fmt(o.v), fmt(e));
            end
        end
        model_lat = 2;
    endtask

    task automatic test_sticky_done();
        clear_queues();
        sticky_done = 1'b1;
        model_lat = 3;
        bus.a1 = 20;
        bus.b1 = 8;
        exp_q.push_back(mk(1, 4, 1'b0, 1'b0));
        bus.req = 2'b10;
        service(1, 50);
        sticky_done = 1'b0;
        model_lat = 2;
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL sticky_count: got %0d acks, need 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o.v !== e) begin
                n_bad++;
                $display("[TB] FAIL sticky_resp: got %s, need %s", fmt(o.v), fmt(e));
            end
        end
    endtask

    task automatic test_req_drop();
        clear_queues();
        model_lat = 4;
        bus.a0 = 35;
        bus.b0 = 49;
        exp_q.push_back(mk(0, 7, 1'b0, 1'b0));
        bus.req = 2'b01;
        repeat (2) @(negedge clk);
        #1;
        bus.req = 2'b00;
        service(1, 50);
        model_lat = 2;
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL drop_count: got %0d acks, need 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o.v !== e) begin
                n_bad++;
                $display("[TB] FAIL drop_resp: got %s, need %s", fmt(o.v), fmt(e));
            end
        end
    endtask

    task automatic test_timeout();
        clear_queues();
        stall_done = 1'b1;
        bus.a1 = 9;
        bus.b1 = 6;
        exp_q.push_back(mk(1, 0, 1'b1, 1'b1));
        bus.req = 2'b10;
        service(1, 200);
        stall_done = 1'b0;
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL timeout_count: got %0d acks, need 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o.v !== e) begin
                n_bad++;
                $display("[TB] FAIL timeout_resp: got %s, need %s", fmt(o.v), fmt(e));
            end
            n_cmp++;
            if (o.cyc != o.start_cyc + 101) begin
                n_bad++;
                $display("[TB] FAIL timeout_latency: got ack cycle %0d, need %0d", o.cyc, o.start_cyc + 101);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        clear_queues();
        model_lat = 20;
        bus.a0 = 30;
        bus.b0 = 45;
        bus.req = 2'b01;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rstwait_busy: got busy=%b, need 1", bus.busy);
        end
        rst = 1'b1;
        bus.req = 2'b00;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.ack, bus.grant, bus.busy, bus.gcd_start} !== 6'b0 || bus.gcd_a !== '0 || bus.gcd_b !== '0) begin
            n_bad++;
            $display("[TB] FAIL rstwait_ctrl: got ack=%b grant=%b busy=%b start=%b a=%0d b=%0d, need all 0",
                     bus.ack, bus.grant, bus.busy, bus.gcd_start, bus.gcd_a, bus.gcd_b);
        end
        n_cmp++;
        if (bus.result !== '0 || bus.error !== 1'b0 || bus.timeout !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL rstwait_resp: got res=%0d err=%b to=%b, need 0 0 0",
                     bus.result, bus.error, bus.timeout);
        end
        rst = 1'b0;
        model_lat = 2;
        repeat (30) @(negedge clk);
        #1;
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL rstwait_noack: got %0d acks, need 0", obs_q.size());
        end
        clear_queues();
        bus.a1 = 14;
        bus.b1 = 21;
        exp_q.push_back(mk(1, 7, 1'b0, 1'b0));
        bus.req = 2'b10;
        service(1, 50);
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL fresh_count: got %0d acks, need 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o.v !== e) begin
                n_bad++;
                $display("[TB] FAIL fresh_resp: got %s, need %s", fmt(o.v), fmt(e));
            end
        end
    endtask

    initial begin
        bus.req = 2'b00;
        bus.a0  = '0;
        bus.b0  = '0;
        bus.a1  = '0;
        bus.b1  = '0;
        test_reset();
        test_basic();
        test_zero_operand();
        test_large();
        test_back_to_back();
        test_round_robin();
        test_isolation();
        test_sticky_done();
        test_req_drop();
        test_timeout();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, need completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
